// File: rtl/imm_gen_pkg.sv
// Shared types and LEGv8 opcode constants for the pipelined immediate generator.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_D     = 3'd1,
        FMT_I     = 3'd2,
        FMT_CB    = 3'd3,
        FMT_B     = 3'd4,
        FMT_IM    = 3'd5,
        FMT_SHAMT = 3'd6
    } fmt_e;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [5:0]  OP_BL   = 6'b100101;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [9:0]  OP_ANDI = 10'b1001001000;
    localparam logic [9:0]  OP_ORRI = 10'b1011001000;
    localparam logic [8:0]  OP_MOVZ = 9'b110100101;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;

    function automatic logic is_imm_arith(input logic [9:0] op);
        return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_ANDI) || (op == OP_ORRI);
    endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational LEGv8 immediate extraction; everything is built at 64 bits and
// truncated to WIDTH so the sign extension is correct for both legal widths.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter bit BR_SHIFT = 1'b1
) (
    input  logic [31:0]      instr_i,
    output logic [WIDTH-1:0] imm_o,
    output fmt_e             fmt_o,
    output logic             illegal_o
);

    localparam bit NARROW = (WIDTH == 32);

    logic [63:0] imm_s;
    logic [63:0] cb_s;
    logic [63:0] b_s;

    assign cb_s = {{45{instr_i[23]}}, instr_i[23:5]};
    assign b_s  = {{38{instr_i[25]}}, instr_i[25:0]};

    // Opcode match in priority order, immediate selection and narrow-width legality
    always_comb begin
        imm_s     = 64'd0;
        fmt_o     = FMT_NONE;
        illegal_o = 1'b0;
        if ((instr_i[31:21] == OP_LDUR) || (instr_i[31:21] == OP_STUR)) begin
            fmt_o = FMT_D;
            imm_s = {{55{instr_i[20]}}, instr_i[20:12]};
        end else if ((instr_i[31:24] == OP_CBZ) || (instr_i[31:24] == OP_CBNZ)) begin
            fmt_o = FMT_CB;
            imm_s = BR_SHIFT ? (cb_s << 2'd2) : cb_s;
        end else if ((instr_i[31:26] == OP_B) || (instr_i[31:26] == OP_BL)) begin
            fmt_o = FMT_B;
            imm_s = BR_SHIFT ? (b_s << 2'd2) : b_s;
        end else if (is_imm_arith(instr_i[31:22])) begin
            fmt_o = FMT_I;
            imm_s = {52'd0, instr_i[21:10]};
        end else if (instr_i[31:23] == OP_MOVZ) begin
            fmt_o = FMT_IM;
            // hw selects a 16-bit lane; lanes 2 and 3 do not exist in a 32-bit result
            if (NARROW && instr_i[22]) begin
                illegal_o = 1'b1;
                imm_s     = 64'd0;
            end else begin
                imm_s = {48'd0, instr_i[20:5]} << {instr_i[22:21], 4'd0};
            end
        end else if ((instr_i[31:21] == OP_LSL) || (instr_i[31:21] == OP_LSR)) begin
            fmt_o = FMT_SHAMT;
            if (NARROW && instr_i[15]) begin
                illegal_o = 1'b1;
                imm_s     = 64'd0;
            end else begin
                imm_s = {58'd0, instr_i[15:10]};
            end
        end else begin
            fmt_o = FMT_NONE;
            imm_s = 64'd0;
        end
    end

    assign imm_o = imm_s[WIDTH-1:0];

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with registered output and a one-entry skid buffer so the
// decode stage can be stalled without losing throughput.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter bit BR_SHIFT = 1'b1,
    parameter int TAG_W    = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] imm,
    output logic [2:0]       fmt,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal,
    output logic [15:0]      illegal_count
);

    typedef struct packed {
        logic [WIDTH-1:0] imm;
        fmt_e             fmt;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } imm_entry_t;

    logic [WIDTH-1:0] dec_imm_s;
    fmt_e             dec_fmt_s;
    logic             dec_illegal_s;
    imm_entry_t       new_s;

    imm_entry_t main_q, main_d, skid_q, skid_d;
    logic       main_valid_q, main_valid_d;
    logic       skid_valid_q, skid_valid_d;
    logic       in_ready_q;
    logic [15:0] cnt_q, cnt_d;
    logic       accept_s, out_fire_s;

    imm_decode #(
        .WIDTH    (WIDTH),
        .BR_SHIFT (BR_SHIFT)
    ) u_decode (
        .instr_i   (instr),
        .imm_o     (dec_imm_s),
        .fmt_o     (dec_fmt_s),
        .illegal_o (dec_illegal_s)
    );

    assign accept_s   = in_valid && in_ready_q;
    assign out_fire_s = main_valid_q && out_ready;

    // Pack the decoded fields with the sideband tag
    always_comb begin
        new_s         = '0;
        new_s.imm     = dec_imm_s;
        new_s.fmt     = dec_fmt_s;
        new_s.tag     = in_tag;
        new_s.illegal = dec_illegal_s;
    end

    // Main/skid steering and the saturating illegal counter
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (out_fire_s && main_q.illegal && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_ready) begin
            // in_ready is low whenever skid is full, so skid and accept never collide here
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept_s) begin
                main_d       = new_s;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_d       = new_s;
                skid_valid_d = 1'b1;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
    end

    // Pipeline state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            cnt_q        <= 16'd0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = main_valid_q;
    assign imm           = main_q.imm;
    assign fmt           = main_q.fmt;
    assign out_tag       = main_q.tag;
    assign illegal       = main_q.illegal;
    assign illegal_count = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomised bench for imm_gen_pipe: a 64-bit/shifted and a 32-bit/word-offset
// instance share stimulus and are checked against a capacity-2 FIFO model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic [63:0] in_tag;
    logic        out_ready;

    logic        in_ready64, out_valid64, illegal64;
    logic [63:0] imm64, tag64;
    logic [2:0]  fmt64;
    logic [15:0] cnt64_o;

    logic        in_ready32, out_valid32, illegal32;
    logic [31:0] imm32;
    logic [63:0] tag32;
    logic [2:0]  fmt32;
    logic [15:0] cnt32_o;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] w;
        logic [63:0] tag;
    } item_t;

    item_t mq[$];
    int    m_cnt64 = 0;
    int    m_cnt32 = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.WIDTH(64), .BR_SHIFT(1'b1), .TAG_W(64)) u_dut64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
        .imm(imm64), .fmt(fmt64), .out_tag(tag64), .illegal(illegal64), .illegal_count(cnt64_o)
    );

    imm_gen_pipe #(.WIDTH(32), .BR_SHIFT(1'b0), .TAG_W(64)) u_dut32 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
        .imm(imm32), .fmt(fmt32), .out_tag(tag32), .illegal(illegal32), .illegal_count(cnt32_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference decode: signed/unsigned integer arithmetic on the instruction fields
    function automatic void ref_dec(input logic [31:0] w, input int wd, input bit brs,
                                    output logic [63:0] imm, output logic [2:0] f, output bit ill);
        longint v;
        int     hw;
        v   = 0;
        f   = 3'd0;
        ill = 1'b0;
        hw  = int'(w[22:21]);
        if (w[31:21] == 11'b11111000010 || w[31:21] == 11'b11111000000) begin
            f = 3'd1;
            v = longint'($signed(w[20:12]));
        end else if (w[31:24] == 8'b10110100 || w[31:24] == 8'b10110101) begin
            f = 3'd3;
            v = longint'($signed(w[23:5]));
            if (brs) v = v * 4;
        end else if (w[31:26] == 6'b000101 || w[31:26] == 6'b100101) begin
            f = 3'd4;
            v = longint'($signed(w[25:0]));
            if (brs) v = v * 4;
        end else if (w[31:22] == 10'b1001000100 || w[31:22] == 10'b1101000100 ||
                     w[31:22] == 10'b1001001000 || w[31:22] == 10'b1011001000) begin
            f = 3'd2;
            v = longint'(w[21:10]);
        end else if (w[31:23] == 9'b110100101) begin
            f = 3'd5;
            if (wd == 32 && hw >= 2) ill = 1'b1;
            else v = longint'(w[20:5]) * (longint'(1) << (16 * hw));
        end else if (w[31:21] == 11'b11010011011 || w[31:21] == 11'b11010011010) begin
            f = 3'd6;
            if (wd == 32 && w[15]) ill = 1'b1;
            else v = longint'(w[15:10]);
        end
        imm = v;
        if (wd == 32) imm = imm & 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        logic [9:0]  iops [4];
        r = $urandom;
        iops[0] = 10'b1001000100; iops[1] = 10'b1101000100;
        iops[2] = 10'b1001001000; iops[3] = 10'b1011001000;
        case ($urandom_range(0, 7))
            0: return {($urandom_range(0, 1) == 1) ? 11'b11111000010 : 11'b11111000000, r[20:0]};
            1: return {7'b1011010, r[24:0]};
            2: return {r[31], 5'b00101, r[25:0]};
            3: return {iops[$urandom_range(0, 3)], r[21:0]};
            4: return {9'b110100101, r[22:0]};
            5: return {10'b1101001101, r[21:0]};
            default: return r;
        endcase
    endfunction

    task automatic compare_all();
        logic [63:0] e_imm;
        logic [2:0]  e_fmt;
        bit          e_ill;
        check_eq("out_valid64", 64'(out_valid64), 64'(mq.size() > 0));
        check_eq("out_valid32", 64'(out_valid32), 64'(mq.size() > 0));
        check_eq("in_ready64", 64'(in_ready64), 64'(mq.size() < 2));
        check_eq("in_ready32", 64'(in_ready32), 64'(mq.size() < 2));
        check_eq("cnt64", 64'(cnt64_o), 64'(m_cnt64));
        check_eq("cnt32", 64'(cnt32_o), 64'(m_cnt32));
        if (mq.size() > 0) begin
            ref_dec(mq[0].w, 64, 1'b1, e_imm, e_fmt, e_ill);
            check_eq("imm64", imm64, e_imm);
            check_eq("fmt64", 64'(fmt64), 64'(e_fmt));
            check_eq("ill64", 64'(illegal64), 64'(e_ill));
            check_eq("tag64", tag64, mq[0].tag);
            ref_dec(mq[0].w, 32, 1'b0, e_imm, e_fmt, e_ill);
            check_eq("imm32", {32'd0, imm32}, e_imm);
            check_eq("fmt32", 64'(fmt32), 64'(e_fmt));
            check_eq("ill32", 64'(illegal32), 64'(e_ill));
            check_eq("tag32", tag32, mq[0].tag);
        end
    endtask

    // Called at a falling edge; drives one cycle, advances the model, checks at the next falling edge
    task automatic step(input bit iv, input logic [31:0] w, input logic [63:0] tg,
                        input bit ordy, input bit fl);
        bit          acc, fire;
        logic [63:0] d_imm;
        logic [2:0]  d_fmt;
        bit          d_ill;
        item_t       it;
        in_valid  = iv;
        instr     = w;
        in_tag    = tg;
        out_ready = ordy;
        flush     = fl;
        acc  = iv && (mq.size() < 2);
        fire = ordy && (mq.size() > 0);
        @(posedge clk);
        if (fire) begin
            ref_dec(mq[0].w, 64, 1'b1, d_imm, d_fmt, d_ill);
            if (d_ill && m_cnt64 < 65535) m_cnt64++;
            ref_dec(mq[0].w, 32, 1'b0, d_imm, d_fmt, d_ill);
            if (d_ill && m_cnt32 < 65535) m_cnt32++;
        end
        if (fl) begin
            mq.delete();
        end else begin
            if (fire) void'(mq.pop_front());
            if (acc) begin
                it.w   = w;
                it.tag = tg;
                mq.push_back(it);
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    logic [31:0] w_l;

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = 32'd0; in_tag = 64'd0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", 64'(out_valid64), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready64), 64'd1);
        check_eq("rst_imm", imm64, 64'd0);
        check_eq("rst_fmt", 64'(fmt64), 64'd0);
        check_eq("rst_tag", tag64, 64'd0);
        check_eq("rst_illegal", 64'(illegal64), 64'd0);
        check_eq("rst_count", 64'(cnt64_o), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        compare_all();

        step(1'b1, {11'b11111000010, 9'h1FF, 12'h000}, 64'h100, 1'b1, 1'b0);
        check_eq("ldur_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("ldur_fmt", 64'(fmt64), 64'd1);
        step(1'b1, {8'b10110100, 19'h7FFFF, 5'd0}, 64'h101, 1'b1, 1'b0);
        check_eq("cbz_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
        step(1'b1, {6'b000101, 26'd1}, 64'h102, 1'b1, 1'b0);
        check_eq("b_imm", imm64, 64'h4);
        check_eq("b_fmt", 64'(fmt64), 64'd4);
        step(1'b1, {9'b110100101, 2'b11, 16'hABCD, 5'd0}, 64'h103, 1'b1, 1'b0);
        check_eq("movz_imm64", imm64, 64'hABCD_0000_0000_0000);
        check_eq("movz_fmt", 64'(fmt64), 64'd5);
        check_eq("movz_imm32", 64'(imm32), 64'd0);
        check_eq("movz_ill32", 64'(illegal32), 64'd1);
        step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        check_eq("movz_cnt32", 64'(cnt32_o), 64'd1);

        // Backpressure: third ADDI must wait for the stall to clear
        step(1'b1, {10'b1001000100, 12'd1, 10'd0}, 64'h201, 1'b0, 1'b0);
        step(1'b1, {10'b1001000100, 12'd2, 10'd0}, 64'h202, 1'b0, 1'b0);
        check_eq("bp_in_ready", 64'(in_ready64), 64'd0);
        step(1'b1, {10'b1001000100, 12'd3, 10'd0}, 64'h203, 1'b0, 1'b0);
        check_eq("bp_first", imm64, 64'd1);
        step(1'b1, {10'b1001000100, 12'd3, 10'd0}, 64'h203, 1'b1, 1'b0);
        check_eq("bp_second", imm64, 64'd2);
        step(1'b1, {10'b1001000100, 12'd3, 10'd0}, 64'h203, 1'b1, 1'b0);
        check_eq("bp_third", imm64, 64'd3);
        check_eq("bp_third_tag", tag64, 64'h203);
        step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);

        step(1'b1, gen_instr(), 64'h301, 1'b0, 1'b0);
        step(1'b1, gen_instr(), 64'h302, 1'b0, 1'b0);
        step(1'b1, gen_instr(), 64'h303, 1'b0, 1'b1);
        check_eq("flush_valid", 64'(out_valid64), 64'd0);
        check_eq("flush_ready", 64'(in_ready64), 64'd1);
        step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);

        step(1'b1, gen_instr(), 64'h401, 1'b0, 1'b0);
        step(1'b1, gen_instr(), 64'h402, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_valid", 64'(out_valid64), 64'd0);
        check_eq("arst_count32", 64'(cnt32_o), 64'd0);
        mq.delete();
        m_cnt64 = 0;
        m_cnt32 = 0;
        @(negedge clk);
        reset = 1'b0;
        compare_all();
        w_l = $urandom;
        step(1'b1, {11'b10001011000, w_l[20:0]}, 64'h501, 1'b1, 1'b0);
        check_eq("add_fmt", 64'(fmt64), 64'd0);
        check_eq("add_imm", imm64, 64'd0);
        check_eq("add_ill", 64'(illegal64), 64'd0);

        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 3) != 0), gen_instr(), 64'(32'h1000 + i) << 8,
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0));
        end
        step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
